// File: rtl/mfp_scanned_seven_segment_display_pkg.sv
// Shared constants and helpers for the scanned seven-segment display engine.
package mfp_scanned_seven_segment_display_pkg;

    // Bit positions inside a segment byte {dp,g,f,e,d,c,b,a}
    localparam int unsigned SEG_A  = 0;
    localparam int unsigned SEG_B  = 1;
    localparam int unsigned SEG_C  = 2;
    localparam int unsigned SEG_D  = 3;
    localparam int unsigned SEG_E  = 4;
    localparam int unsigned SEG_F  = 5;
    localparam int unsigned SEG_G  = 6;
    localparam int unsigned SEG_DP = 7;

    typedef enum logic {
        MODE_STATIC = 1'b0,
        MODE_SCAN   = 1'b1
    } disp_mode_e;

    // Hex glyphs 0..F, active-high, bit order {g,f,e,d,c,b,a}; b and d are lower case
    localparam logic [6:0] GLYPH_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    // Converts an active-high segment byte to the board's drive level
    function automatic logic [7:0] apply_polarity(input logic [7:0] bits, input bit active_low);
        return active_low ? ~bits : bits;
    endfunction

    // Active-high segment byte for one digit: dark digits override everything,
    // LZ-blanked digits keep only their decimal point
    function automatic logic [7:0] encode_digit(input logic [3:0] nibble, input logic dp,
                                                input logic lz_blank, input logic enable);
        logic [6:0] glyph;
        logic [7:0] seg;
        glyph = GLYPH_TABLE[nibble];
        seg   = '0;
        if (enable) begin
            seg[SEG_DP] = dp;
            if (!lz_blank) begin
                seg[SEG_A] = glyph[0];
                seg[SEG_B] = glyph[1];
                seg[SEG_C] = glyph[2];
                seg[SEG_D] = glyph[3];
                seg[SEG_E] = glyph[4];
                seg[SEG_F] = glyph[5];
                seg[SEG_G] = glyph[6];
            end
        end
        return seg;
    endfunction

endpackage

// File: rtl/mfp_seven_segment_lz_mask.sv
// Leading-zero blank mask: marks zero digits above the first significant digit.
module mfp_seven_segment_lz_mask
    import mfp_scanned_seven_segment_display_pkg::*;
#(
    parameter int unsigned N_DIGITS = 6
) (
    input  logic [4*N_DIGITS-1:0] value,
    input  logic [N_DIGITS-1:0]   dp,
    input  logic                  blank_lz,
    output logic [N_DIGITS-1:0]   blank
);

    // Walk from the most significant digit down; a non-zero nibble or a lit dp ends the run.
    // Digit 0 is never visited, so it always stays visible.
    always_comb begin
        logic        leading;
        int unsigned i;
        blank   = '0;
        leading = blank_lz;
        i       = 0;
        for (int unsigned k = 0; k + 1 < N_DIGITS; k++) begin
            i = N_DIGITS - 1 - k;
            if ((value[4*i +: 4] != 4'h0) || dp[i]) begin
                leading = 1'b0;
            end
            blank[i] = leading;
        end
    end

endmodule

// File: rtl/mfp_scanned_seven_segment_display.sv
// N-digit hex display: static per-digit segment buses plus a multiplexed scan bus.
module mfp_scanned_seven_segment_display
    import mfp_scanned_seven_segment_display_pkg::*;
#(
    parameter int unsigned N_DIGITS       = 6,
    parameter int unsigned SCAN_DIV       = 50000,
    parameter int unsigned GHOST_BLANK    = 2,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          DIG_ACTIVE_LOW = 1'b1
) (
    input  logic                  SI_ClkIn,
    input  logic                  SI_Reset,
    input  logic [4*N_DIGITS-1:0] value,
    input  logic [N_DIGITS-1:0]   dp,
    input  logic [N_DIGITS-1:0]   digit_en,
    input  logic                  blank_lz,
    input  logic                  mode,
    input  logic                  load,
    output logic [8*N_DIGITS-1:0] hex_static,
    output logic [7:0]            scan_seg,
    output logic [N_DIGITS-1:0]   scan_dig,
    output logic                  frame_tick
);

    localparam int unsigned IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int unsigned PRE_W = $clog2(SCAN_DIV);

    localparam logic [PRE_W-1:0]    PRE_LAST  = PRE_W'(SCAN_DIV - 1);
    localparam logic [PRE_W-1:0]    GHOST_END = PRE_W'(GHOST_BLANK);
    localparam logic [IDX_W-1:0]    IDX_LAST  = IDX_W'(N_DIGITS - 1);
    localparam logic [7:0]          SEG_OFF   = apply_polarity(8'h00, SEG_ACTIVE_LOW);
    localparam logic [N_DIGITS-1:0] DIG_OFF   = {N_DIGITS{DIG_ACTIVE_LOW}};

    logic [4*N_DIGITS-1:0] pend_value, com_value;
    logic [N_DIGITS-1:0]   pend_dp, com_dp;
    logic [N_DIGITS-1:0]   pend_en, com_en;

    logic [PRE_W-1:0]      prescaler;
    logic [IDX_W-1:0]      digit_idx;
    disp_mode_e            mode_q;
    disp_mode_e            mode_now;

    logic                  mode_change;
    logic                  scanning;
    logic                  at_boundary;
    logic [N_DIGITS-1:0]   lz_blank;
    logic [7:0]            seg_on [N_DIGITS];
    logic [N_DIGITS-1:0]   dig_sel;

    assign mode_now    = disp_mode_e'(mode);
    assign mode_change = (mode_now != mode_q);
    assign scanning    = (mode_now == MODE_SCAN) && !mode_change;
    assign at_boundary = scanning && (prescaler == PRE_LAST) && (digit_idx == IDX_LAST);
    assign frame_tick  = at_boundary;

    // Slot prescaler and digit index; any mode transition restarts the scan at digit 0
    always_ff @(posedge SI_ClkIn) begin
        if (SI_Reset) begin
            prescaler <= '0;
            digit_idx <= '0;
            mode_q    <= MODE_STATIC;
        end else begin
            mode_q <= mode_now;
            if (mode_change) begin
                prescaler <= '0;
                digit_idx <= '0;
            end else if (mode_now == MODE_SCAN) begin
                if (prescaler == PRE_LAST) begin
                    prescaler <= '0;
                    digit_idx <= (digit_idx == IDX_LAST) ? '0 : digit_idx + 1'b1;
                end else begin
                    prescaler <= prescaler + 1'b1;
                end
            end
        end
    end

    // Pending capture on load; committed frame only changes between scan frames,
    // with a boundary-cycle load bypassing pending so it lands in the next frame
    always_ff @(posedge SI_ClkIn) begin
        if (SI_Reset) begin
            pend_value <= '0;
            pend_dp    <= '0;
            pend_en    <= '0;
            com_value  <= '0;
            com_dp     <= '0;
            com_en     <= '0;
        end else begin
            if (load) begin
                pend_value <= value;
                pend_dp    <= dp;
                pend_en    <= digit_en;
            end
            if (mode_change || (mode_now == MODE_STATIC)) begin
                com_value <= pend_value;
                com_dp    <= pend_dp;
                com_en    <= pend_en;
            end else if (at_boundary) begin
                com_value <= load ? value    : pend_value;
                com_dp    <= load ? dp       : pend_dp;
                com_en    <= load ? digit_en : pend_en;
            end
        end
    end

    mfp_seven_segment_lz_mask #(
        .N_DIGITS (N_DIGITS)
    ) u_lz_mask (
        .value    (com_value),
        .dp       (com_dp),
        .blank_lz (blank_lz),
        .blank    (lz_blank)
    );

    for (genvar g = 0; g < N_DIGITS; g++) begin : g_decode
        assign seg_on[g] = encode_digit(com_value[4*g +: 4], com_dp[g], lz_blank[g], com_en[g]);
    end

    // Anode one-hot for the current slot, suppressed during the anti-ghost interval
    always_comb begin
        dig_sel = '0;
        if (prescaler >= GHOST_END) begin
            dig_sel[digit_idx] = 1'b1;
        end
    end

    // Registered outputs: static buses always track committed, scan bus only while scanning
    always_ff @(posedge SI_ClkIn) begin
        if (SI_Reset) begin
            hex_static <= {N_DIGITS{SEG_OFF}};
            scan_seg   <= SEG_OFF;
            scan_dig   <= DIG_OFF;
        end else begin
            for (int unsigned i = 0; i < N_DIGITS; i++) begin
                hex_static[8*i +: 8] <= apply_polarity(seg_on[i], SEG_ACTIVE_LOW);
            end
            if (scanning) begin
                scan_seg <= apply_polarity(seg_on[digit_idx], SEG_ACTIVE_LOW);
                scan_dig <= dig_sel ^ DIG_OFF;
            end else begin
                scan_seg <= SEG_OFF;
                scan_dig <= DIG_OFF;
            end
        end
    end

endmodule

// File: tb/tb_mfp_scanned_seven_segment_display.sv
// Scoreboard bench for the scanned seven-segment display (6 digits, 4-cycle slots).
module tb_mfp_scanned_seven_segment_display;

    logic        SI_ClkIn = 1'b0;
    logic        SI_Reset;
    logic [23:0] value;
    logic [5:0]  dp;
    logic [5:0]  digit_en;
    logic        blank_lz;
    logic        mode;
    logic        load;
    logic [47:0] hex_static;
    logic [7:0]  scan_seg;
    logic [5:0]  scan_dig;
    logic        frame_tick;

    mfp_scanned_seven_segment_display #(
        .N_DIGITS       (6),
        .SCAN_DIV       (4),
        .GHOST_BLANK    (1),
        .SEG_ACTIVE_LOW (1'b1),
        .DIG_ACTIVE_LOW (1'b1)
    ) dut (
        .SI_ClkIn   (SI_ClkIn),
        .SI_Reset   (SI_Reset),
        .value      (value),
        .dp         (dp),
        .digit_en   (digit_en),
        .blank_lz   (blank_lz),
        .mode       (mode),
        .load       (load),
        .hex_static (hex_static),
        .scan_seg   (scan_seg),
        .scan_dig   (scan_dig),
        .frame_tick (frame_tick)
    );

    initial forever #5 SI_ClkIn = ~SI_ClkIn;

    int cyc = 0;
    initial forever begin
        @(posedge SI_ClkIn);
        cyc++;
    end

    typedef enum {K_HEX, K_SEG, K_DIG, K_TICK} kind_e;
    typedef struct {
        int          due;
        kind_e       kind;
        logic [47:0] exp;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Active-low glyph bytes per digit index (digit 0 first)
    logic [7:0] seg_abcdef [6] = '{8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88};
    logic [7:0] seg_123456 [6] = '{8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9};
    logic [7:0] seg_987654 [6] = '{8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    task automatic push_exp(input int due, input kind_e k, input logic [47:0] v, input string nm);
        exp_t e;
        e.due  = due;
        e.kind = k;
        e.exp  = v;
        e.name = nm;
        sb.push_back(e);
    endtask

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge SI_ClkIn);
            #1;
        end
    endtask

    // Monitor: on each falling edge, compare every entry due this cycle
    initial begin
        int          i;
        logic [47:0] act;
        forever begin
            @(negedge SI_ClkIn);
            i = 0;
            while (i < sb.size()) begin
                if (sb[i].due <= cyc) begin
                    case (sb[i].kind)
                        K_HEX:   act = hex_static;
                        K_SEG:   act = {40'h0, scan_seg};
                        K_DIG:   act = {42'h0, scan_dig};
                        default: act = {47'h0, frame_tick};
                    endcase
                    n_tests++;
                    if (sb[i].due < cyc) begin
                        n_fail++;
                        $display("FAIL %s @cycle %0d: check missed (now cycle %0d)", sb[i].name, sb[i].due, cyc);
                    end else if (act !== sb[i].exp) begin
                        n_fail++;
                        $display("FAIL %s @cycle %0d: got %h, expected %h", sb[i].name, cyc, act, sb[i].exp);
                    end
                    sb.delete(i);
                end else begin
                    i++;
                end
            end
        end
    end

    task automatic static_load(input int t, input logic [23:0] v, input logic [5:0] d,
                               input logic [5:0] en, input logic lz,
                               input logic [47:0] exp_hex, input string nm);
        goto(t);
        value = v; dp = d; digit_en = en; blank_lz = lz; load = 1'b1;
        push_exp(t + 3, K_HEX, exp_hex, nm);
        goto(t + 1);
        load = 1'b0;
    endtask

    task automatic run_scan_tests();
        int         m;
        int         slot;
        logic [5:0] d;
        logic [5:0] tog_dig [8];
        int         t_tog;
        int         r;

        // Scan entry with ABCDEF committed
        goto(50);
        value = 24'hABCDEF; dp = 6'h00; digit_en = 6'h3F; blank_lz = 1'b0; load = 1'b1;
        goto(51);
        load = 1'b0;
        m = 56;
        goto(m);
        mode = 1'b1;
        push_exp(m + 1, K_DIG, 48'h3F, "scan_dig_enter");
        for (int k = 0; k < 96; k++) begin
            slot = (k / 4) % 6;
            d    = 6'h01 << slot;
            push_exp(m + 2 + k, K_DIG, (k % 4 == 0) ? 48'h3F : {42'h0, ~d}, "scan_dig_seq");
            if (k < 48) push_exp(m + 2 + k, K_SEG, {40'h0, seg_abcdef[slot]}, "scan_seg_abcdef");
        end
        for (int c = 1; c <= 96; c++) begin
            push_exp(m + c, K_TICK, ((c - 1) % 24 == 23) ? 48'h1 : 48'h0, "frame_tick_period");
        end

        // Mid-frame load during digit 2: held off until next frame
        goto(m + 34);
        value = 24'h123456; load = 1'b1;
        push_exp(m + 45, K_HEX, 48'h8883C6A1868E, "hex_hold_midframe");
        push_exp(m + 49, K_HEX, 48'h8883C6A1868E, "hex_hold_boundary");
        push_exp(m + 50, K_HEX, 48'hF9A4B0999282, "hex_after_commit");
        for (int k = 48; k < 72; k++) begin
            push_exp(m + 2 + k, K_SEG, {40'h0, seg_123456[(k / 4) % 6]}, "scan_seg_123456");
        end
        goto(m + 35);
        load = 1'b0;

        // Load coinciding with frame_tick bypasses into the very next frame
        goto(m + 72);
        value = 24'h987654; load = 1'b1;
        push_exp(m + 73, K_HEX, 48'hF9A4B0999282, "hex_before_bypass");
        push_exp(m + 74, K_HEX, 48'h9080F8829299, "hex_after_bypass");
        for (int k = 72; k < 96; k++) begin
            push_exp(m + 2 + k, K_SEG, {40'h0, seg_987654[(k / 4) % 6]}, "scan_seg_bypass");
        end
        goto(m + 73);
        load = 1'b0;

        // Mode toggle 1->0->1 mid-slot restarts the scan with no tick
        t_tog = m + 103;
        tog_dig = '{6'h3F, 6'h3F, 6'h3F, 6'h3E, 6'h3E, 6'h3E, 6'h3F, 6'h3D};
        goto(t_tog);
        mode = 1'b0;
        for (int j = 0; j < 8; j++) push_exp(t_tog + 1 + j, K_DIG, {42'h0, tog_dig[j]}, "toggle_dig");
        push_exp(t_tog + 3, K_SEG, 48'h99, "toggle_seg_digit0");
        for (int c = t_tog; c <= t_tog + 38; c++) begin
            push_exp(c, K_TICK, (c == t_tog + 25) ? 48'h1 : 48'h0, "toggle_tick");
        end
        goto(t_tog + 1);
        mode = 1'b1;

        // Reset during digit 3
        r = t_tog + 39;
        goto(r);
        SI_Reset = 1'b1;
        push_exp(r + 1, K_HEX, 48'hFFFFFFFFFFFF, "midreset_hex");
        push_exp(r + 1, K_SEG, 48'hFF, "midreset_seg");
        push_exp(r + 1, K_DIG, 48'h3F, "midreset_dig");
        push_exp(r + 2, K_DIG, 48'h3F, "postreset_dig0");
        push_exp(r + 3, K_DIG, 48'h3F, "postreset_ghost");
        push_exp(r + 4, K_DIG, 48'h3E, "postreset_digit0");
        push_exp(r + 5, K_SEG, 48'hFF, "postreset_seg_dark");
        for (int c = r + 1; c <= r + 25; c++) begin
            push_exp(c, K_TICK, (c == r + 25) ? 48'h1 : 48'h0, "postreset_tick");
        end
        goto(r + 1);
        SI_Reset = 1'b0;
        goto(r + 30);
    endtask

    initial begin
        SI_Reset = 1'b1;
        value    = '0;
        dp       = '0;
        digit_en = '0;
        blank_lz = 1'b0;
        mode     = 1'b0;
        load     = 1'b0;

        push_exp(2, K_HEX,  48'hFFFFFFFFFFFF, "reset_hex");
        push_exp(2, K_SEG,  48'hFF, "reset_seg");
        push_exp(2, K_DIG,  48'h3F, "reset_dig");
        push_exp(2, K_TICK, 48'h0, "reset_tick");
        goto(3);
        SI_Reset = 1'b0;

        // Static mode decode, latency and blanking
        push_exp(8, K_HEX, 48'hFFFFFFFFFFFF, "static_latency_t2");
        push_exp(9, K_DIG, 48'h3F, "static_dig_idle");
        push_exp(9, K_SEG, 48'hFF, "static_seg_idle");
        static_load(6,  24'h012345, 6'h00, 6'h3F, 1'b0, 48'hC0F9A4B09992, "static_012345");
        static_load(12, 24'h012345, 6'h00, 6'h3F, 1'b1, 48'hFFF9A4B09992, "lz_012345");
        static_load(18, 24'h000000, 6'h00, 6'h3F, 1'b1, 48'hFFFFFFFFFFC0, "lz_all_zero");
        static_load(24, 24'h000000, 6'h04, 6'h3F, 1'b1, 48'hFFFFFF40C0C0, "lz_stop_at_dp");
        static_load(30, 24'h001020, 6'h00, 6'h3F, 1'b1, 48'hFFFFF9C0A4C0, "lz_inner_zeros");
        static_load(36, 24'h000000, 6'h3F, 6'h1E, 1'b1, 48'hFF40404040FF, "dark_priority");

        // Load held for two cycles captures both values
        goto(42);
        value = 24'h111111; dp = 6'h00; digit_en = 6'h3F; blank_lz = 1'b0; load = 1'b1;
        push_exp(45, K_HEX, 48'hF9F9F9F9F9F9, "held_load_first");
        push_exp(46, K_HEX, 48'hA4A4A4A4A4A4, "held_load_second");
        goto(43);
        value = 24'h222222;
        goto(44);
        load = 1'b0;

        run_scan_tests();

        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d checks left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mfp_scanned_seven_segment_display.md
Name: mfp_scanned_seven_segment_display

Overview:
- Parametrised N-digit hex display engine, successor to the fixed six-digit static decode on the board top level.
- Takes the IO_7_SegmentHEX-style nibble vector plus per-digit decimal points and enables.
- Drives two output sets: static per-digit segment buses, and a time-multiplexed single-bus segment/anode scan for boards with shared segment lines.
- Features: tear-free frame commit, leading-zero blanking, anti-ghost blanking interval.

Parameters:
- N_DIGITS, 6: number of digits, 1..16.
- SCAN_DIV, 50000: clock cycles per digit slot in scan mode, at least 2.
- GHOST_BLANK, 2: cycles at the start of each slot with all anodes off, less than SCAN_DIV.
- SEG_ACTIVE_LOW, 1: 1 means a lit segment is driven 0.
- DIG_ACTIVE_LOW, 1: 1 means the selected anode is driven 0.

Ports:
- SI_ClkIn, in, 1: clock.
- SI_Reset, in, 1: synchronous active-high reset.
- value, in, 4*N_DIGITS: nibble i maps to digit i; digit 0 is least significant.
- dp, in, N_DIGITS: decimal point per digit, 1 = lit.
- digit_en, in, N_DIGITS: 0 = digit forced dark.
- blank_lz, in, 1: enables leading-zero blanking.
- mode, in, 1: 0 = static, 1 = scan.
- load, in, 1: single-cycle strobe that captures value, dp and digit_en into the pending register.
- hex_static, out, 8*N_DIGITS: byte i holds {dp,g,f,e,d,c,b,a} for digit i.
- scan_seg, out, 8: {dp,g..a} for the currently selected digit.
- scan_dig, out, N_DIGITS: anode selects, one-hot in the active sense.
- frame_tick, out, 1: one-cycle pulse at the end of the last digit slot.

Behaviour:
- Clocking and reset: one clock domain, SI_ClkIn. SI_Reset is synchronous and active-high.
- On reset:
  - prescaler = 0, digit index = 0.
  - pending and committed registers = 0, with digit_en = 0.
  - hex_static and scan_seg at the inactive level: all 1s when SEG_ACTIVE_LOW = 1.
  - scan_dig all inactive, frame_tick = 0.
- Reset mid-frame aborts the scan immediately; the next cycle behaves as the first cycle after reset.
- Capture: load at cycle t writes pending at the t+1 edge. A load held high for several cycles captures every cycle.
- Static mode (mode = 0):
  - committed <= pending every cycle.
  - hex_static is registered from committed, so a load at t is visible on hex_static at t+3.
  - scan_dig is held inactive; scan_seg is inactive.
- Scan mode (mode = 1):
  - The prescaler counts 0..SCAN_DIV-1. At SCAN_DIV-1 the digit index increments and wraps from N_DIGITS-1 to 0.
  - Frame boundary: prescaler = SCAN_DIV-1 and digit index = N_DIGITS-1. At a boundary, frame_tick = 1 for that cycle and committed <= pending.
  - If load is asserted in the boundary cycle, the new inputs bypass pending into committed.
  - hex_static keeps tracking committed in scan mode.
- Scan outputs (registered, one-cycle latency from counter state):
  - scan_seg = decode(committed digit[idx]).
  - scan_dig selects idx only when prescaler >= GHOST_BLANK; otherwise all anodes are inactive.
- Mode change: a 0->1 or 1->0 transition resets the prescaler and digit index to 0 and commits pending immediately. frame_tick is not pulsed on this event.
- Decode:
  - Nibbles 0..F map to the standard hex glyphs; b and d are lower case.
  - Segment and anode polarity are applied last, after all blanking.
- Leading-zero blanking, when blank_lz = 1:
  - Scan from digit N_DIGITS-1 downward. Digits whose nibble is 0 are blanked until the first non-zero nibble or the first digit with dp = 1.
  - Digit 0 is never LZ-blanked.
  - An LZ-blanked digit shows no a..g segments but still shows its dp.
- A digit with digit_en = 0 has all 8 bits inactive, dp included. digit_en = 0 takes priority over LZ.
- Width rules: all digit-indexed widths scale with N_DIGITS. The index counter is $clog2(N_DIGITS) bits, minimum 1. The prescaler is $clog2(SCAN_DIV) bits.

Decomposition:
- Shared package constants:
  - Segment bit positions (SEG_A..SEG_G, SEG_DP).
  - The 16-entry glyph table, stored active-high.
  - A polarity-apply function.
- Sub-module: mfp_seven_segment_lz_mask. This is combinational and produces the N_DIGITS blank mask from value, dp and blank_lz. It is instantiated once and feeds both the static path and the scan path.
- Glyph decode is an N-way generate of the package function.

Test Plan (bench configuration: N_DIGITS = 6, SCAN_DIV = 4, GHOST_BLANK = 1, both polarities active-low, both settings of blank_lz exercised):
- Reset, then static mode, load value = 24'h012345, digit_en = 6'h3F, blank_lz = 0. Required: at t+3, hex_static byte 0 = 8'h92 ('5') and byte 5 = 8'hC0 ('0'). scan_dig stays 6'h3F.
- Same load with blank_lz = 1. Required: byte 5 = 8'hFF. With value = 0 and dp = 0, bytes 5..1 = 8'hFF and byte 0 = 8'hC0.
- Scan mode, value = 24'hABCDEF. Required:
  - scan_dig sequence 3F, 3E, 3E, 3E, 3F, 3D, … (one inactive cycle per slot).
  - scan_seg while digit 0 is selected = 8'h8E ('F').
  - frame_tick is exactly one cycle every 24 cycles.
- Scan mode: load a new value mid-frame (digit 2). Required: digits 3..5 in the remainder of that frame still show the old nibbles; the new value appears from digit 0 of the next frame. Repeat with load coinciding with frame_tick: the new value appears in the immediately following frame.
- Toggle mode 1->0->1 mid-slot, and assert SI_Reset during digit 3. Required: the index restarts at 0 and the prescaler at 0, with no frame_tick. After reset, all outputs are inactive (8'hFF / 6'h3F).
- Dark-digit priority: digit_en = 6'b011110 with dp = 6'h3F. Required: bytes 0 and 5 = 8'hFF, and no digit dp is lost on enabled LZ-blanked digits (bit 7 = 0).
